video_capture: RTL and testbench

- Sink for the core's VGA pixel stream (video_r/g/b, video_de, video_hsync, video_vsync, video_newframe) in the vclk domain.
- On request, grabs one complete frame, decimated 2:1 in both axes, and writes it as 12-bit RGB words into a capture RAM write port.
- Continuously measures active width and height of the incoming stream, for self-test and screenshot support.

---
 rtl/video_capture.sv | 112 +++++++++++
 tb/tb_video_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_capture.sv
// video_capture: grabs one 2:1-decimated video frame into a capture RAM and
// continuously measures the active width/height of the incoming pixel stream.
module video_capture #(
  parameter int CAP_W  = 320,
  parameter int CAP_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cap_start,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              cap_overflow,
  input  logic [3:0]        video_r,
  input  logic [3:0]        video_g,
  input  logic [3:0]        video_b,
  input  logic              video_de,
  input  logic              video_hsync,
  input  logic              video_vsync,
  input  logic              video_newframe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              wr_en,
  output logic [9:0]        meas_width,
  output logic [9:0]        meas_height,
  output logic              meas_valid
);
  localparam logic [ADDR_W:0] CAP_N = (ADDR_W+1)'(CAP_W * CAP_H);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic de_q, rise, fall, sel, unused_sync;
  logic [9:0] px_cnt_q, px_cnt_d, px_base, line_cnt_q, line_cnt_d, line_cur, line_w_q;
  logic [9:0] meas_width_q, meas_height_q;
  logic meas_valid_q, ovf_q, ovf_d, wr_en_q, wr_en_d;
  logic [ADDR_W:0] addr_q, addr_d;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [11:0] wr_data_q;
  assign unused_sync = video_hsync ^ video_vsync;
  assign rise = video_de & ~de_q;
  assign fall = ~video_de & de_q;
  // px_base/line_cur are the counts a pixel is judged by: pixel count before
  // this cycle's increment, line count after it
  assign px_base = rise ? 10'd0 : px_cnt_q;
  assign line_cur = (rise && !(&line_cnt_q)) ? line_cnt_q + 10'd1 : line_cnt_q;
  assign px_cnt_d = !video_de ? px_cnt_q : (&px_base) ? px_base : px_base + 10'd1;
  assign line_cnt_d = video_newframe ? 10'd0 : line_cur;
  assign sel = video_de & ~px_base[0] & line_cur[0];
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    ovf_d = ovf_q;
    wr_en_d = 1'b0;
    case (state_q)
      IDLE: if (cap_start) begin
        state_d = WAIT_FRAME;
        ovf_d = 1'b0;
        addr_d = '0;
      end
      WAIT_FRAME: if (video_newframe) state_d = CAPTURE;
      CAPTURE: if (video_newframe) state_d = DONE;
        else if (sel && addr_q < CAP_N) begin
          wr_en_d = 1'b1;
          addr_d = addr_q + (ADDR_W+1)'(1);
        end else if (sel) ovf_d = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      de_q <= 1'b0;
      px_cnt_q <= '0;
      line_cnt_q <= '0;
      line_w_q <= '0;
      meas_width_q <= '0;
      meas_height_q <= '0;
      meas_valid_q <= 1'b0;
      addr_q <= '0;
      ovf_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      de_q <= video_de;
      px_cnt_q <= px_cnt_d;
      line_cnt_q <= line_cnt_d;
      if (fall) line_w_q <= px_cnt_q;
      if (video_newframe) begin
        meas_width_q <= line_w_q;
        meas_height_q <= line_cnt_q;
        meas_valid_q <= line_cnt_q != 10'd0;
      end
      addr_q <= addr_d;
      ovf_q <= ovf_d;
      wr_en_q <= wr_en_d;
      if (wr_en_d) begin
        wr_addr_q <= addr_q[ADDR_W-1:0];
        wr_data_q <= {video_r, video_g, video_b};
      end
    end
  end
  assign cap_busy = state_q != IDLE;
  assign cap_done = state_q == DONE;
  assign cap_overflow = ovf_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign meas_width = meas_width_q;
  assign meas_height = meas_height_q;
  assign meas_valid = meas_valid_q;
endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: randomized frames against a decimation/measurement reference
// model, run on a scaled-down capture size to keep simulation short.
module tb_video_capture;
  localparam int CW = 32, CH = 24, AW = 10, N = CW * CH;
  logic clk = 1'b0, reset_n = 1'b0, cap_start = 1'b0;
  logic cap_busy, cap_done, cap_overflow, wr_en, meas_valid;
  logic [3:0] video_r = '0, video_g = '0, video_b = '0;
  logic video_de = 1'b0, video_hsync = 1'b0, video_vsync = 1'b0, video_newframe = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [11:0] wr_data;
  logic [9:0] meas_width, meas_height;
  int checks = 0, failures = 0, dones = 0, consec = 0;
  logic wr_en_prev = 1'b0;
  int wa[$];
  logic [11:0] wd[$], ed[$];

  video_capture #(.CAP_W(CW), .CAP_H(CH), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .cap_start(cap_start), .cap_busy(cap_busy),
    .cap_done(cap_done), .cap_overflow(cap_overflow), .video_r(video_r),
    .video_g(video_g), .video_b(video_b), .video_de(video_de),
    .video_hsync(video_hsync), .video_vsync(video_vsync),
    .video_newframe(video_newframe), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .meas_width(meas_width), .meas_height(meas_height),
    .meas_valid(meas_valid));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(int'(wr_addr));
      wd.push_back(wr_data);
    end
    if (wr_en && wr_en_prev) consec++;
    wr_en_prev = wr_en;
    if (cap_done) dones++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int x, input int y, input logic [11:0] s);
    return {4'(x), 4'(y), 4'h5} ^ s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse on the first pixel of line pulse_line (-1: none)
  task automatic send_frame(input int w, input int h, input logic [11:0] s, input int pulse_line);
    video_newframe = 1'b1;
    tick();
    video_newframe = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        video_de = 1'b1;
        {video_r, video_g, video_b} = pix(x, y, s);
        cap_start = (y == pulse_line && x == 0);
        tick();
      end
      video_de = 1'b0;
      cap_start = 1'b0;
      repeat ($urandom_range(2, 6)) tick();
    end
    repeat (4) tick();
  endtask

  task automatic end_frame(input bit start_on_done);
    video_newframe = 1'b1;
    tick();
    video_newframe = 1'b0;
    cap_start = start_on_done;
    tick();
    cap_start = 1'b0;
    repeat (4) tick();
  endtask

  task automatic start_pulse();
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    tick();
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    dones = 0;
    consec = 0;
  endtask

  // reference: even rows and even columns in raster order, first N kept
  task automatic compare_writes(input string tag, input int w, input int h, input logic [11:0] s);
    int bad = 0;
    ed.delete();
    for (int y = 0; y < h; y += 2)
      for (int x = 0; x < w; x += 2)
        if (ed.size() < N) ed.push_back(pix(x, y, s));
    check({tag, "_count"}, wa.size(), ed.size());
    for (int i = 0; i < wa.size() && i < ed.size(); i++)
      if (wa[i] != i || wd[i] != ed[i]) bad++;
    check({tag, "_content_errs"}, bad, 0);
    check({tag, "_done"}, dones, 1);
    check({tag, "_b2b_wr"}, consec, 0);
    check({tag, "_busy"}, int'(cap_busy), 0);
  endtask

  initial begin
    logic [11:0] s;
    repeat (3) tick();
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_busy", int'(cap_busy), 0);
    check("rst_done", int'(cap_done), 0);
    check("rst_ovf", int'(cap_overflow), 0);
    check("rst_addr", int'(wr_addr), 0);
    check("rst_data", int'(wr_data), 0);
    check("rst_mvalid", int'(meas_valid), 0);
    check("rst_mw", int'(meas_width), 0);
    reset_n = 1'b1;
    repeat (2) tick();
    video_newframe = 1'b1;
    tick();
    video_newframe = 1'b0;
    tick();
    check("first_nf_mvalid", int'(meas_valid), 0);

    // full frame, start before newframe
    clear_log();
    s = 12'($urandom);
    start_pulse();
    check("a_busy", int'(cap_busy), 1);
    send_frame(64, 48, s, -1);
    end_frame(1'b0);
    compare_writes("a", 64, 48, s);
    check("a_ovf", int'(cap_overflow), 0);
    check("a_mw", int'(meas_width), 64);
    check("a_mh", int'(meas_height), 48);
    check("a_mvalid", int'(meas_valid), 1);

    // start mid-frame, then stray starts in CAPTURE and on DONE
    clear_log();
    send_frame(64, 48, 12'($urandom), 10);
    check("b_nowr_midframe", wa.size(), 0);
    check("b_busy_wait", int'(cap_busy), 1);
    s = 12'($urandom);
    send_frame(64, 48, s, 5);
    end_frame(1'b1);
    compare_writes("b", 64, 48, s);
    repeat (20) tick();
    check("b_idle_after", int'(cap_busy), 0);

    // two extra lines overflow the capture buffer
    clear_log();
    s = 12'($urandom);
    start_pulse();
    send_frame(64, 50, s, -1);
    end_frame(1'b0);
    compare_writes("c", 64, 50, s);
    check("c_ovf", int'(cap_overflow), 1);
    check("c_mh", int'(meas_height), 50);

    // reset in the middle of a capture
    clear_log();
    send_frame(64, 48, 12'($urandom), 2);
    check("c2d_ovf_cleared", int'(cap_overflow), 0);
    fork
      send_frame(64, 48, 12'($urandom), -1);
      begin
        int k = 0;
        while (wa.size() < 100 && k < 20000) begin
          @(negedge clk);
          k++;
        end
        check("d_reach_100", int'(wa.size() >= 100), 1);
        check("d_mvalid_before", int'(meas_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("d_rst_wr_en", int'(wr_en), 0);
        check("d_rst_busy", int'(cap_busy), 0);
        check("d_rst_mvalid", int'(meas_valid), 0);
      end
    join
    check("d_no_done", dones, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    clear_log();
    s = 12'($urandom);
    start_pulse();
    send_frame(64, 48, s, -1);
    end_frame(1'b0);
    compare_writes("d_clean", 64, 48, s);

    // short frame
    clear_log();
    s = 12'($urandom);
    start_pulse();
    check("e_ovf_cleared", int'(cap_overflow), 0);
    send_frame(32, 20, s, -1);
    end_frame(1'b0);
    compare_writes("e", 32, 20, s);
    check("e_ovf", int'(cap_overflow), 0);
    check("e_mw", int'(meas_width), 32);
    check("e_mh", int'(meas_height), 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
